imul_iter_ctrl: RTL
===================

IMUL_ITER_CTRL -- requirements
Module: imul_iter_ctrl

Interface
REQ-001 The block SHALL have parameter NB, default 16, which sets the operand width in bits.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port iStart, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port iA, input, NB bits: unsigned multiplicand.
REQ-006 The block SHALL have port iB, input, NB bits: unsigned multiplier.
REQ-007 The block SHALL have port oBusy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port oDone, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port oResult, output, 2*NB bits: unsigned product.

Function
REQ-010 The block SHALL implement the FSM states IDLE, ITER and DONE.
REQ-011 In IDLE, a rising edge with iStart=1 SHALL capture iA and iB into internal registers, clear the accumulator and iteration counter, and enter ITER.
REQ-012 In ITER, each edge SHALL add (A_reg AND replicated B_reg[k]) into the upper NB+1 bits of the accumulator, shift the accumulator right by one bit, and increment counter k.
REQ-013 ITER SHALL last exactly NB edges; the edge on which k=NB-1 SHALL transition to DONE.
REQ-014 Latency: oDone SHALL be high for exactly one cycle, starting NB+1 edges after the edge that sampled iStart; the latency is fixed and independent of operand values, including zero operands.
REQ-015 oResult SHALL equal iA*iB (mod 2^(2*NB), exact for unsigned operands) from the DONE cycle onward, and SHALL hold that value until the edge that accepts the next iStart.
REQ-016 oResult SHALL NOT expose partial sums: it SHALL be driven from a result register loaded on entry to DONE.
REQ-017 oBusy SHALL be 1 in ITER and 0 in IDLE and DONE.
REQ-018 iStart SHALL be ignored while in ITER; iA/iB changes in ITER SHALL NOT affect the result in progress.
REQ-019 In DONE, iStart=1 SHALL be accepted as in IDLE (back-to-back; next state ITER); otherwise the next state SHALL be IDLE.
REQ-020 Addition SHALL be unsigned with NB+1-bit width so the carry-out of every add is retained; no overflow is possible.

Reset
REQ-021 Reset=1 at an edge SHALL force state IDLE, counter 0, and accumulator, operand and result registers to 0, with priority over all other inputs.
REQ-022 After reset, oBusy=0, oDone=0 and oResult=0.
REQ-023 Reset asserted mid-ITER SHALL abort the operation with no oDone pulse.
REQ-024 iStart sampled on an edge where Reset=1 SHALL be discarded.

Structure
REQ-025 The FSM state encodings (IDLE=2'd0, ITER=2'd1, DONE=2'd2) SHALL live in a shared header of `define constants, reused by sibling IMUL blocks.
REQ-026 The NB+1-bit add SHALL be one sub-module, imul_add_row, built as a ripple chain of the existing full_adder cell.
REQ-027 Controller logic (FSM, counter, operand, accumulator and result registers) SHALL reside in imul_iter_ctrl.
REQ-028 Counter width SHALL be $clog2(NB) bits.

Verification
REQ-029 The bench SHALL cover: iA=3, iB=5, iStart pulse -> oDone exactly 17 edges later, oResult=32'h0000000F, oBusy high for 16 cycles.
REQ-030 The bench SHALL cover: iA=16'hFFFF, iB=16'hFFFF -> oResult=32'hFFFE0001 at oDone.
REQ-031 The bench SHALL cover: iA=0, iB=16'h1234 -> oDone still after 17 edges, oResult=0.
REQ-032 The bench SHALL cover: iStart re-pulsed with iA=7, iB=7 at ITER cycle 5 of a 3x5 operation -> ignored, result 15, exactly one oDone.
REQ-033 The bench SHALL cover: Reset at ITER cycle 8 -> next cycle oBusy=0, oResult=0, no oDone; a fresh 2x9 operation then returns 18.
REQ-034 The bench SHALL cover: iStart held high through DONE with new operands 10x10 -> oDone cycle shows 15, then ITER resumes immediately, next oDone 17 edges later with oResult=100.

Source files
------------

// File: rtl/imul_iter_ctrl_pkg.sv
// imul_iter_ctrl_pkg: FSM state encodings shared by the IMUL family of iterative blocks.
`ifndef IMUL_STATE_DEFS
`define IMUL_STATE_DEFS
`define IMUL_IDLE 2'd0
`define IMUL_ITER 2'd1
`define IMUL_DONE 2'd2
`endif

package imul_iter_ctrl_pkg;
   localparam logic [1:0] IDLE = `IMUL_IDLE;
   localparam logic [1:0] ITER = `IMUL_ITER;
   localparam logic [1:0] DONE = `IMUL_DONE;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/imul_add_row.sv
// imul_add_row: W-bit ripple-carry adder whose carry-out forms the top bit of a W+1-bit sum.
module imul_add_row #(
   parameter int W = 16
) (
   input  logic [W-1:0] iX,
   input  logic [W-1:0] iY,
   output logic [W:0]   oSum
);
   logic [W:0] carry;
   assign carry[0] = 1'b0;
   assign oSum[W]  = carry[W];
   for (genvar i = 0; i < W; i++) begin : gBit
      full_adder uFa (.a(iX[i]), .b(iY[i]), .ci(carry[i]), .s(oSum[i]), .co(carry[i+1]));
   end
endmodule

// File: rtl/imul_iter_ctrl.sv
// imul_iter_ctrl: shift-add unsigned multiplier, one partial product per clock,
// fixed NB-cycle iteration with a registered result and single-cycle done pulse.
module imul_iter_ctrl
   import imul_iter_ctrl_pkg::*;
#(
   parameter int NB = 16
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            iStart,
   input  logic [NB-1:0]   iA,
   input  logic [NB-1:0]   iB,
   output logic            oBusy,
   output logic            oDone,
   output logic [2*NB-1:0] oResult
);
   localparam int KW = NB > 1 ? $clog2(NB) : 1;
   logic [1:0]      state;
   logic [KW-1:0]   k;
   logic [NB-1:0]   aReg, bReg;
   logic [2*NB-1:1] acc;
   logic [2*NB-1:0] result, accNext;
   logic [NB:0]     rowSum;
   // Bit 0 of the shifted accumulator is only meaningful on the final step, so it is never stored.
   imul_add_row #(.W(NB)) uRow (
      .iX(acc[2*NB-1:NB]),
      .iY(aReg & {NB{bReg[k]}}),
      .oSum(rowSum)
   );
   assign accNext = {rowSum, acc[NB-1:1]};
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= IDLE;
         k      <= '0;
         aReg   <= '0;
         bReg   <= '0;
         acc    <= '0;
         result <= '0;
      end else if (state == ITER) begin
         acc <= accNext[2*NB-1:1];
         k   <= k + KW'(1);
         if (k == KW'(NB-1)) begin
            state  <= DONE;
            result <= accNext;
         end
      end else if (iStart) begin
         aReg  <= iA;
         bReg  <= iB;
         acc   <= '0;
         k     <= '0;
         state <= ITER;
      end else begin
         state <= IDLE;
      end
   end
   assign oBusy   = state == ITER;
   assign oDone   = state == DONE;
   assign oResult = result;
endmodule
